// File: rtl/uart_reg_bridge_if.sv
// rtl/uart_reg_bridge_if.sv - UART and register-bus signal bundle for uart_reg_bridge
// Purpose: groups the UART RX/TX handshake, the register-file bus and the status
//          flags of the bridge so they travel as one port.
// Signals:
//   RX_BYTEs_i / RX_DONE_i            received byte and its 1-cycle strobe
//   TX_BYTEs_o / TX_REQ_o / TX_ACK_i  byte to transmit, request level, accept pulse
//   ADRs_o / WDATs_o / WT_o / RD_o    register address, write data, strobes
//   RDATs_i                           register read data (combinational from the file)
//   BUSY_o / OVF_o / TMO_o            not idle, sticky dropped byte, write timeout pulse
// Modports: master = the bridge, slave = UART cores plus register file.
interface uart_reg_bridge_if #(
   parameter int C_DAT_W = 8,
   parameter int C_ADR_W = 4
);
   logic [7:0]         RX_BYTEs_i;
   logic               RX_DONE_i;
   logic [7:0]         TX_BYTEs_o;
   logic               TX_REQ_o;
   logic               TX_ACK_i;
   logic [C_ADR_W-1:0] ADRs_o;
   logic [C_DAT_W-1:0] WDATs_o;
   logic               WT_o;
   logic               RD_o;
   logic [C_DAT_W-1:0] RDATs_i;
   logic               BUSY_o;
   logic               OVF_o;
   logic               TMO_o;

   modport master (
      input  RX_BYTEs_i, RX_DONE_i, TX_ACK_i, RDATs_i,
      output TX_BYTEs_o, TX_REQ_o, ADRs_o, WDATs_o, WT_o, RD_o, BUSY_o, OVF_o, TMO_o
   );

   modport slave (
      output RX_BYTEs_i, RX_DONE_i, TX_ACK_i, RDATs_i,
      input  TX_BYTEs_o, TX_REQ_o, ADRs_o, WDATs_o, WT_o, RD_o, BUSY_o, OVF_o, TMO_o
   );
endinterface

// File: rtl/uart_reg_bridge.sv
// rtl/uart_reg_bridge.sv - UART byte-command to register-bus bridge
// Purpose: decodes write (cmd bit7=1, then data byte) and read (cmd bit7=0)
//          commands from the UART RX core, drives single-cycle WT/RD strobes on
//          the register bus and returns read data or a write ACK byte (8'h06)
//          to the UART TX core over a REQ/ACK handshake. All outputs registered.
// Ports:
//   CK_i     clock
//   XARST_i  asynchronous reset, active low
//   bus      uart_reg_bridge_if.master (UART RX/TX, register bus, status flags)
module uart_reg_bridge #(
   parameter int C_DAT_W  = 8,
   parameter int C_ADR_W  = 4,
   parameter int C_TMO    = 1000,
   parameter int C_WT_ACK = 1
) (
   input  logic              CK_i,
   input  logic              XARST_i,
   uart_reg_bridge_if.master bus
);
   localparam int               CNT_W    = (C_TMO > 1) ? $clog2(C_TMO) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_TMO - 1);
   localparam logic [7:0]       ACK_BYTE = 8'h06;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_DAT,
      S_WRITE,
      S_READ,
      S_TX_WAIT
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [C_ADR_W-1:0] adr_q, adr_d;
   logic [C_DAT_W-1:0] wdat_q, wdat_d;
   logic [7:0]         tx_byte_q, tx_byte_d;
   logic               tx_req_q, tx_req_d;
   logic               wt_q, wt_d;
   logic               rd_q, rd_d;
   logic               busy_q, busy_d;
   logic               ovf_q, ovf_d;
   logic               tmo_q, tmo_d;

   always_ff @(posedge CK_i or negedge XARST_i) begin
      if (!XARST_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         adr_q     <= '0;
         wdat_q    <= '0;
         tx_byte_q <= '0;
         tx_req_q  <= 1'b0;
         wt_q      <= 1'b0;
         rd_q      <= 1'b0;
         busy_q    <= 1'b0;
         ovf_q     <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         adr_q     <= adr_d;
         wdat_q    <= wdat_d;
         tx_byte_q <= tx_byte_d;
         tx_req_q  <= tx_req_d;
         wt_q      <= wt_d;
         rd_q      <= rd_d;
         busy_q    <= busy_d;
         ovf_q     <= ovf_d;
         tmo_q     <= tmo_d;
      end
   end

   // Strobes and TX_REQ are computed for the state being entered, so the
   // registered outputs line up with the registered state.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      adr_d     = adr_q;
      wdat_d    = wdat_q;
      tx_byte_d = tx_byte_q;
      tx_req_d  = tx_req_q;
      wt_d      = 1'b0;
      rd_d      = 1'b0;
      ovf_d     = ovf_q;
      tmo_d     = 1'b0;

      // Bytes arriving while a bus cycle or reply is in flight cannot be queued.
      if (bus.RX_DONE_i && (state_q == S_WRITE || state_q == S_READ || state_q == S_TX_WAIT)) begin
         ovf_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (bus.RX_DONE_i) begin
               adr_d = bus.RX_BYTEs_i[C_ADR_W-1:0];
               if (bus.RX_BYTEs_i[7]) begin
                  state_d = S_GET_DAT;
                  cnt_d   = '0;
               end else begin
                  state_d = S_READ;
                  rd_d    = 1'b1;
               end
            end
         end
         S_GET_DAT: begin
            // A data byte in the last allowed cycle still wins over the timeout.
            if (bus.RX_DONE_i) begin
               wdat_d  = bus.RX_BYTEs_i[C_DAT_W-1:0];
               state_d = S_WRITE;
               wt_d    = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               tmo_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WRITE: begin
            if (C_WT_ACK != 0) begin
               tx_byte_d = ACK_BYTE;
               tx_req_d  = 1'b1;
               state_d   = S_TX_WAIT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_READ: begin
            // RDATs_i is valid during the RD_o cycle; capture it zero-extended.
            tx_byte_d = 8'(bus.RDATs_i);
            tx_req_d  = 1'b1;
            state_d   = S_TX_WAIT;
         end
         S_TX_WAIT: begin
            if (bus.TX_ACK_i) begin
               tx_req_d = 1'b0;
               state_d  = S_IDLE;
            end
         end
         default: begin
            state_d  = S_IDLE;
            tx_req_d = 1'b0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   assign bus.TX_BYTEs_o = tx_byte_q;
   assign bus.TX_REQ_o   = tx_req_q;
   assign bus.ADRs_o     = adr_q;
   assign bus.WDATs_o    = wdat_q;
   assign bus.WT_o       = wt_q;
   assign bus.RD_o       = rd_q;
   assign bus.BUSY_o     = busy_q;
   assign bus.OVF_o      = ovf_q;
   assign bus.TMO_o      = tmo_q;
endmodule
